// File: rtl/avr_regfile_if.sv
// Bus between the write selector / operand consumers / debug controller and avr_regfile.
// The master modport drives addresses, data and enables; the slave modport is the register file.
interface avr_regfile_if;
   logic [4:0]  waddr;
   logic [15:0] wdata;
   logic        we_byte;
   logic        we_word;
   logic [4:0]  raddr_d;
   logic [4:0]  raddr_r;
   logic [15:0] rdata_d;
   logic [15:0] rdata_r;
   logic [15:0] x_ptr;
   logic [15:0] y_ptr;
   logic [15:0] z_ptr;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic        dbg_ack;
   logic [7:0]  dbg_rdata;

   modport master (
      output waddr, wdata, we_byte, we_word, raddr_d, raddr_r, dbg_req, dbg_addr,
      input  rdata_d, rdata_r, x_ptr, y_ptr, z_ptr, dbg_ack, dbg_rdata
   );

   modport slave (
      input  waddr, wdata, we_byte, we_word, raddr_d, raddr_r, dbg_req, dbg_addr,
      output rdata_d, rdata_r, x_ptr, y_ptr, z_ptr, dbg_ack, dbg_rdata
   );
endinterface

// File: rtl/avr_regfile.sv
// AVR 32x8 register file: byte/pair writes, two pair-read ports, X/Y/Z pointers, debug read port.
// Optional macro RF_BYPASS_EN forwards in-flight write data to the read ports and pointers.
module avr_regfile #(
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input logic         clk,
   input logic         rst_n,
   avr_regfile_if.slave bus
);

   typedef enum logic {
      S_IDLE,
      S_ACK
   } dbg_state_e;

   logic [7:0] regs_q  [32];
   logic [7:0] regs_d  [32];
   logic [7:0] rd_view [32];

   dbg_state_e state_q, state_d;
   logic [7:0] dbg_rdata_q, dbg_rdata_d;

   // Word write takes priority over a simultaneous byte write; waddr[0] is ignored for pairs.
   always_comb begin
      for (int unsigned i = 0; i < 32; i++) begin
         regs_d[i[4:0]] = regs_q[i[4:0]];
      end
      if (bus.we_word) begin
         regs_d[{bus.waddr[4:1], 1'b0}] = bus.wdata[7:0];
         regs_d[{bus.waddr[4:1], 1'b1}] = bus.wdata[15:8];
      end else if (bus.we_byte) begin
         regs_d[bus.waddr] = bus.wdata[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) begin
            regs_q[i[4:0]] <= RESET_VAL;
         end
      end else begin
         for (int unsigned i = 0; i < 32; i++) begin
            regs_q[i[4:0]] <= regs_d[i[4:0]];
         end
      end
   end

`ifdef RF_BYPASS_EN
   assign rd_view = regs_d;
`else
   assign rd_view = regs_q;
`endif

   assign bus.rdata_d = {rd_view[{bus.raddr_d[4:1], 1'b1}], rd_view[bus.raddr_d]};
   assign bus.rdata_r = {rd_view[{bus.raddr_r[4:1], 1'b1}], rd_view[bus.raddr_r]};
   assign bus.x_ptr   = {rd_view[27], rd_view[26]};
   assign bus.y_ptr   = {rd_view[29], rd_view[28]};
   assign bus.z_ptr   = {rd_view[31], rd_view[30]};

   // Debug data is sampled post-write so a same-edge write to the target register is seen.
   always_comb begin
      state_d     = state_q;
      dbg_rdata_d = dbg_rdata_q;
      case (state_q)
         S_IDLE:  if (bus.dbg_req) state_d = S_ACK;
         S_ACK:   state_d = bus.dbg_req ? S_ACK : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (bus.dbg_req) begin
         dbg_rdata_d = regs_d[bus.dbg_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         dbg_rdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign bus.dbg_ack   = (state_q == S_ACK);
   assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_avr_regfile.sv
// Self-checking bench for avr_regfile: directed plan steps plus random traffic against an array model.
module tb_avr_regfile;

   localparam logic [7:0] RST_V = 8'h00;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [7:0] mdl [32];
   logic       exp_ack;
   logic [7:0] exp_dbg;

   avr_regfile_if bif ();

   avr_regfile #(.RESET_VAL(RST_V)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bif.we_byte = 1'b0;
      bif.we_word = 1'b0;
      bif.dbg_req = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mdl[i] = RST_V;
      exp_ack = 1'b0;
      exp_dbg = 8'h00;
   endtask

   // One clock: checks read ports/pointers mid-cycle, advances the model at the edge, checks debug.
   task automatic cycle();
      logic [7:0] nxt [32];
      logic [7:0] v   [32];
      logic       req;
      logic [4:0] da;
      logic [4:0] rd, rr;
      @(negedge clk);
      nxt = mdl;
      if (bif.we_word) begin
         nxt[bif.waddr & 5'h1E] = bif.wdata[7:0];
         nxt[bif.waddr | 5'h01] = bif.wdata[15:8];
      end else if (bif.we_byte) begin
         nxt[bif.waddr] = bif.wdata[7:0];
      end
`ifdef RF_BYPASS_EN
      v = nxt;
`else
      v = mdl;
`endif
      rd = bif.raddr_d;
      rr = bif.raddr_r;
      chk("rdata_d", bif.rdata_d, {v[rd | 5'h01], v[rd]});
      chk("rdata_r", bif.rdata_r, {v[rr | 5'h01], v[rr]});
      chk("x_ptr", bif.x_ptr, {v[27], v[26]});
      chk("y_ptr", bif.y_ptr, {v[29], v[28]});
      chk("z_ptr", bif.z_ptr, {v[31], v[30]});
      req = bif.dbg_req;
      da  = bif.dbg_addr;
      @(posedge clk);
      mdl     = nxt;
      exp_ack = req;
      if (req) exp_dbg = nxt[da];
      #1;
      chk("dbg_ack", {15'd0, bif.dbg_ack}, {15'd0, exp_ack});
      chk("dbg_rdata", {8'd0, bif.dbg_rdata}, {8'd0, exp_dbg});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bif.waddr    = '0;
      bif.wdata    = '0;
      bif.raddr_d  = '0;
      bif.raddr_r  = '0;
      bif.dbg_addr = '0;
      idle();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ack", {15'd0, bif.dbg_ack}, 16'h0000);
      chk("rst_dbg", {8'd0, bif.dbg_rdata}, 16'h0000);

      for (int a = 0; a < 32; a++) begin
         bif.raddr_d = 5'(a);
         bif.raddr_r = 5'(31 - a);
         cycle();
         chk("rst_rd", bif.rdata_d, 16'h0000);
      end

      // Byte write to odd register leaves its even partner alone.
      bif.we_byte = 1'b1; bif.waddr = 5'd17; bif.wdata = 16'hBEEF; bif.raddr_d = 5'd17;
      cycle();
      idle();
      bif.raddr_d = 5'd16; bif.raddr_r = 5'd17;
      #1;
      chk("byte_r16", bif.rdata_d, 16'hEF00);
      chk("byte_r17", bif.rdata_r, 16'hEFEF);

      // Word write at odd address lands on the even-aligned pair.
      bif.we_word = 1'b1; bif.waddr = 5'd27; bif.wdata = 16'h1234; bif.raddr_d = 5'd26;
      cycle();
      idle();
      bif.raddr_r = 5'd28;
      #1;
      chk("word_x", bif.x_ptr, 16'h1234);
      chk("word_r28", bif.rdata_r, 16'h0000);

      bif.we_word = 1'b1; bif.we_byte = 1'b1; bif.waddr = 5'd30; bif.wdata = 16'hA55A;
      cycle();
      idle();
      #1;
      chk("both_z", bif.z_ptr, 16'hA55A);

      // Debug read of a register written at the same edge.
      bif.we_byte = 1'b1; bif.waddr = 5'd26; bif.wdata = 16'h0077;
      bif.dbg_req = 1'b1; bif.dbg_addr = 5'd26;
      cycle();
      chk("dbg_same_ack", {15'd0, bif.dbg_ack}, 16'h0001);
      chk("dbg_same_data", {8'd0, bif.dbg_rdata}, 16'h0077);
      idle();

      bif.we_word = 1'b1; bif.waddr = 5'd1; bif.wdata = 16'h2211;
      cycle();
      idle();
      bif.we_byte = 1'b1; bif.waddr = 5'd2; bif.wdata = 16'h0033;
      cycle();
      idle();
      bif.dbg_req = 1'b1; bif.dbg_addr = 5'd0;
      cycle();
      chk("b2b_0", {7'd0, bif.dbg_ack, bif.dbg_rdata}, 16'h0111);
      bif.dbg_addr = 5'd1;
      cycle();
      chk("b2b_1", {7'd0, bif.dbg_ack, bif.dbg_rdata}, 16'h0122);
      bif.dbg_addr = 5'd2;
      cycle();
      chk("b2b_2", {7'd0, bif.dbg_ack, bif.dbg_rdata}, 16'h0133);
      idle();
      cycle();
      chk("b2b_end", {7'd0, bif.dbg_ack, bif.dbg_rdata}, 16'h0033);

      for (int n = 0; n < 400; n++) begin
         bif.waddr    = 5'($urandom_range(0, 31));
         bif.wdata    = 16'($urandom);
         bif.we_byte  = ($urandom_range(0, 2) == 0);
         bif.we_word  = ($urandom_range(0, 3) == 0);
         bif.raddr_d  = ($urandom_range(0, 1) == 0) ? bif.waddr : 5'($urandom_range(0, 31));
         bif.raddr_r  = 5'($urandom_range(0, 31));
         bif.dbg_req  = ($urandom_range(0, 2) == 0);
         bif.dbg_addr = ($urandom_range(0, 1) == 0) ? bif.waddr : 5'($urandom_range(0, 31));
         cycle();
      end

      // Asynchronous reset in the middle of a word write.
      bif.we_word = 1'b1; bif.we_byte = 1'b0; bif.waddr = 5'd24; bif.wdata = 16'hC3A5;
      bif.dbg_req = 1'b1; bif.dbg_addr = 5'd24; bif.raddr_d = 5'd24;
      cycle();
      chk("pre_rst", {7'd0, bif.dbg_ack, bif.dbg_rdata}, 16'h01A5);
      bif.wdata = 16'h5A5A;
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_r24", bif.rdata_d, 16'h0000);
      chk("mid_rst_ack", {15'd0, bif.dbg_ack}, 16'h0000);
      chk("mid_rst_dbg", {8'd0, bif.dbg_rdata}, 16'h0000);
      idle();
      #1;
      rst_n = 1'b1;
      repeat (3) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avr_regfile.md
Name: avr_regfile

Overview:
- 32 x 8-bit general-purpose register file (R0..R31) for the AVR CPU core.
- Sits directly downstream of the register-file write address/data selector. It consumes waddr, wdata, we_byte and we_word from that selector and stores the result on the clock edge.
- Supplies two operand read ports (byte or register-pair) to the ALU/MUL/bit units, plus dedicated X/Y/Z pointer outputs for the address generator.
- A handshaked debug read port lets the debug controller inspect any register.

Parameters:
- RESET_VAL, 8'h00, value loaded into every register on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- waddr  input  5  write address from the write selector
- wdata  input  16  write data; [7:0] for byte writes, [15:0] for pair writes
- we_byte  input  1  byte write enable
- we_word  input  1  register-pair write enable
- raddr_d  input  5  operand D read address
- raddr_r  input  5  operand R read address
- rdata_d  output  16  operand D: [7:0]=R[raddr_d], [15:8]=R[{raddr_d[4:1],1}]
- rdata_r  output  16  operand R, same format as rdata_d
- x_ptr  output  16  {R27,R26}
- y_ptr  output  16  {R29,R28}
- z_ptr  output  16  {R31,R30}
- dbg_req  input  1  debug read request
- dbg_addr  input  5  debug read address
- dbg_ack  output  1  debug read acknowledge (registered)
- dbg_rdata  output  8  debug read data (registered)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0): all 32 registers = RESET_VAL; dbg_ack=0; dbg_rdata=8'h00. Reset asserted mid-write aborts the write; registers still read RESET_VAL.
- Byte write: we_byte=1 and we_word=0 -> R[waddr] <= wdata[7:0] at the rising edge.
- Word write: we_word=1 -> R[{waddr[4:1],0}] <= wdata[7:0] and R[{waddr[4:1],1}] <= wdata[15:8] at the same edge. waddr[0] is ignored (odd address is forced even).
- we_byte=1 and we_word=1 together (illegal): the word write wins; no byte write occurs.
- Neither enable set: no state change. waddr/wdata are don't-care and must not be X-propagated into storage.
- Read ports: combinational from storage, zero latency. An odd raddr returns the pair {R[raddr], R[raddr]} in hi/lo positions, because [15:8] indexes {raddr[4:1],1}.
- Same-cycle read of an address being written returns the OLD value unless RF_BYPASS_EN is defined.
- Pointers: always reflect current storage; same bypass rule as the read ports.
- Debug port: two-state FSM, IDLE -> ACK when dbg_req=1.
  - In ACK: dbg_ack=1 for exactly one cycle. dbg_rdata = R[dbg_addr] sampled at the request edge, post-write (a write to the same register at that edge is included).
  - ACK -> ACK if dbg_req is still 1 (back-to-back request, new dbg_addr sampled). ACK -> IDLE otherwise.
  - dbg_rdata holds its value while in IDLE.
- Latency: write visible on read ports one cycle after the write edge (zero with bypass). Debug latency is one cycle.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: rdata_d, rdata_r, x_ptr, y_ptr and z_ptr forward the in-flight write data per byte lane. The byte and word write rules above apply, so a word write forwards both bytes of the pair. Read-after-write in the same cycle returns the NEW value.
- Undefined: outputs are pure storage reads; same-cycle reads return the OLD value. Storage contents and the debug port are identical in both builds.

Test Plan:
- Reset release then read all 32 registers via raddr_d -> every byte 8'h00; dbg_ack=0; x_ptr=y_ptr=z_ptr=16'h0000.
- we_byte, waddr=5'd17, wdata=16'hBEEF -> next cycle R17=8'hEF and R16 unchanged; with the bypass build, rdata_d=raddr 17 shows 8'hEF in the same cycle.
- we_word, waddr=5'd27 (odd), wdata=16'h1234 -> R26=8'h34, R27=8'h12, x_ptr=16'h1234, R28 unchanged.
- we_byte=we_word=1, waddr=5'd30, wdata=16'hA55A -> z_ptr=16'hA55A (word wins).
- dbg_req pulsed with dbg_addr=5'd26 in the same cycle as a byte write of 8'h77 to R26 -> next cycle dbg_ack=1, dbg_rdata=8'h77. Holding dbg_req for 3 cycles with addresses 0,1,2 -> three consecutive acks with the matching data.
- rst_n asserted during a word write to R24 -> R24=R25=8'h00 immediately, dbg_ack drops to 0 asynchronously.
